// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths for the architectural register file and its ROB interface.
package register_file_pkg;
  localparam int REG_POS_WID = 5;
  localparam int DATA_WID    = 32;
  localparam int ROB_POS_WID = 4;
  localparam int ROB_SIZE    = 1 << ROB_POS_WID;
endpackage

// File: rtl/register_file_read_port.sv
// reg_read_port: one decoder query port with x0 forcing and same-cycle commit bypass.
module reg_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W    = DATA_WID,
  parameter int ROB_POS_W = ROB_POS_WID
) (
  input  logic [REG_POS_WID-1:0] rs_pos,
  input  logic [DATA_W-1:0]      st_val,
  input  logic                   st_busy,
  input  logic [ROB_POS_W-1:0]   st_tag,
  input  logic                   reg_write,
  input  logic [REG_POS_WID-1:0] reg_rd,
  input  logic [DATA_W-1:0]      reg_val,
  input  logic [ROB_POS_W-1:0]   commit_rob_pos,
  output logic [DATA_W-1:0]      rs_val,
  output logic                   rs_busy,
  output logic [ROB_POS_W-1:0]   rs_tag
);
  logic zero, byp;
  always_comb begin
    zero    = rs_pos == '0;
    byp     = st_busy && reg_write && reg_rd == rs_pos && st_tag == commit_rob_pos;
    rs_val  = zero ? '0 : byp ? reg_val : st_val;
    rs_busy = !zero && st_busy && !byp;
    rs_tag  = zero ? '0 : st_tag;
  end
endmodule

// File: rtl/register_file.sv
// register_file: committed register values plus per-register rename tags, with two bypassed query ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int DATA_W    = DATA_WID,
  parameter int ROB_POS_W = ROB_POS_WID
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   issue,
  input  logic [REG_POS_WID-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0]   issue_rob_pos,
  input  logic                   reg_write,
  input  logic [REG_POS_WID-1:0] reg_rd,
  input  logic [DATA_W-1:0]      reg_val,
  input  logic [ROB_POS_W-1:0]   commit_rob_pos,
  input  logic [REG_POS_WID-1:0] rs1_pos,
  input  logic [REG_POS_WID-1:0] rs2_pos,
  output logic [DATA_W-1:0]      rs1_val,
  output logic [DATA_W-1:0]      rs2_val,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [ROB_POS_W-1:0]   rs1_tag,
  output logic [ROB_POS_W-1:0]   rs2_tag
);
  logic [DATA_W-1:0]    val_q [REG_NUM];
  logic [DATA_W-1:0]    val_d [REG_NUM];
  logic [ROB_POS_W-1:0] tag_q [REG_NUM];
  logic [ROB_POS_W-1:0] tag_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q, busy_d;
  // Commit is applied first so a same-cycle issue (or rollback) overrides its busy/tag effect.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (reg_write && reg_rd != '0) begin
      val_d[reg_rd] = reg_val;
      if (tag_q[reg_rd] == commit_rob_pos) busy_d[reg_rd] = 1'b0;
    end
    if (rollback) begin
      busy_d = '0;
      tag_d  = '{default: '0};
    end else if (issue && issue_rd != '0) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_rob_pos;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
    end else if (rdy) begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end
  reg_read_port #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W)) u_rs1 (
    .rs_pos(rs1_pos), .st_val(val_q[rs1_pos]), .st_busy(busy_q[rs1_pos]), .st_tag(tag_q[rs1_pos]),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val), .commit_rob_pos(commit_rob_pos),
    .rs_val(rs1_val), .rs_busy(rs1_busy), .rs_tag(rs1_tag)
  );
  reg_read_port #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W)) u_rs2 (
    .rs_pos(rs2_pos), .st_val(val_q[rs2_pos]), .st_busy(busy_q[rs2_pos]), .st_tag(tag_q[rs2_pos]),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val), .commit_rob_pos(commit_rob_pos),
    .rs_val(rs2_val), .rs_busy(rs2_busy), .rs_tag(rs2_tag)
  );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of reset, rename, commit bypass, rollback, x0 and rdy stall.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, issue, reg_write;
  logic [4:0]  issue_rd, reg_rd, rs1_pos, rs2_pos;
  logic [3:0]  issue_rob_pos, commit_rob_pos, rs1_tag, rs2_tag;
  logic [31:0] reg_val, rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val), .commit_rob_pos(commit_rob_pos),
    .rs1_pos(rs1_pos), .rs2_pos(rs2_pos),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; rdy = 1; rollback = 0; issue = 0; reg_write = 0;
    issue_rd = 0; issue_rob_pos = 0; reg_rd = 0; reg_val = 0; commit_rob_pos = 0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
    issue = 1; issue_rd = rd; issue_rob_pos = pos;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] pos, input logic [31:0] v);
    reg_write = 1; reg_rd = rd; commit_rob_pos = pos; reg_val = v;
  endtask

  initial begin
    idle();
    rst = 1; rs1_pos = 5; rs2_pos = 0;
    cyc(); cyc();
    rst = 0; #1;
    chk("rst_rs1_val", rs1_val, 0);  chk("rst_rs1_busy", rs1_busy, 0); chk("rst_rs1_tag", rs1_tag, 0);
    chk("rst_rs2_val", rs2_val, 0);  chk("rst_rs2_busy", rs2_busy, 0); chk("rst_rs2_tag", rs2_tag, 0);
    // issue x3 -> pos 2; same-cycle query must not see it
    do_issue(3, 2); rs1_pos = 3; #1;
    chk("issue_not_same_cycle", rs1_busy, 0);
    cyc(); idle();
    chk("x3_busy", rs1_busy, 1); chk("x3_tag", rs1_tag, 2);
    do_commit(3, 2, 32'hDEAD); #1;
    chk("x3_bypass_val", rs1_val, 32'hDEAD); chk("x3_bypass_busy", rs1_busy, 0);
    cyc(); idle(); #1;
    chk("x3_stored_val", rs1_val, 32'hDEAD); chk("x3_stored_busy", rs1_busy, 0);
    // younger producer keeps x4 busy
    do_issue(4, 1); cyc(); do_issue(4, 5); cyc(); idle();
    do_commit(4, 1, 7); rs1_pos = 4; #1;
    chk("x4_nobypass_val", rs1_val, 0); chk("x4_nobypass_busy", rs1_busy, 1);
    cyc(); idle(); #1;
    chk("x4_val", rs1_val, 7); chk("x4_busy", rs1_busy, 1); chk("x4_tag", rs1_tag, 5);
    // same-cycle issue and commit on x6
    do_issue(6, 8); cyc(); idle();
    do_issue(6, 9); do_commit(6, 8, 11); rs2_pos = 6; #1;
    chk("x6_bypass_val", rs2_val, 11); chk("x6_bypass_busy", rs2_busy, 0);
    cyc(); idle(); #1;
    chk("x6_val", rs2_val, 11); chk("x6_busy", rs2_busy, 1); chk("x6_tag", rs2_tag, 9);
    // rollback with commit and ignored issue
    do_issue(2, 3); cyc(); do_issue(7, 4); cyc(); idle();
    rs1_pos = 2; rs2_pos = 7; #1;
    chk("x2_busy", rs1_busy, 1); chk("x2_tag", rs1_tag, 3);
    chk("x7_busy", rs2_busy, 1); chk("x7_tag", rs2_tag, 4);
    rollback = 1; do_commit(1, 0, 32'h40); do_issue(9, 6);
    cyc(); idle();
    rs1_pos = 1; rs2_pos = 2; #1;
    chk("rb_x1_val", rs1_val, 32'h40); chk("rb_x1_busy", rs1_busy, 0);
    chk("rb_x2_busy", rs2_busy, 0); chk("rb_x2_tag", rs2_tag, 0);
    rs1_pos = 7; rs2_pos = 9; #1;
    chk("rb_x7_busy", rs1_busy, 0); chk("rb_x9_busy", rs2_busy, 0);
    rs1_pos = 6; rs2_pos = 4; #1;
    chk("rb_x6_busy", rs1_busy, 0); chk("rb_x6_val", rs1_val, 11);
    chk("rb_x4_tag", rs2_tag, 0); chk("rb_x4_val", rs2_val, 7);
    // x0 stays zero
    do_issue(0, 3); do_commit(0, 3, 32'h123); rs1_pos = 0; #1;
    chk("x0_same_val", rs1_val, 0);
    cyc(); idle(); #1;
    chk("x0_val", rs1_val, 0); chk("x0_busy", rs1_busy, 0); chk("x0_tag", rs1_tag, 0);
    // rdy low drops the cycle
    rdy = 0; do_issue(8, 7); do_commit(8, 7, 32'h55);
    cyc(); idle();
    rs1_pos = 8; #1;
    chk("stall_x8_busy", rs1_busy, 0); chk("stall_x8_val", rs1_val, 0);
    // tag wrap 15 -> 0 compares by equality
    do_issue(10, 15); cyc(); do_issue(11, 0); cyc(); idle();
    do_commit(10, 15, 32'h99); rs1_pos = 10; rs2_pos = 11; #1;
    chk("wrap_x10_bypass", rs1_val, 32'h99); chk("wrap_x11_busy", rs2_busy, 1);
    cyc(); idle(); #1;
    chk("wrap_x10_busy", rs1_busy, 0); chk("wrap_x11_tag", rs2_tag, 0);
    // reset beats rollback and clears values
    rst = 1; rollback = 1; rs1_pos = 3; cyc(); idle(); #1;
    chk("rst2_x3_val", rs1_val, 0); chk("rst2_x11_busy", rs2_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
